// File: rtl/xctcmsg_pkg.sv
// Shared types for the xctcmsg ring: FU-side message and ring flit formats.
package xctcmsg_pkg;

  localparam int RING_ADDR_W = 32;
  localparam int RING_PAY_W  = 64;

  typedef struct packed {
    logic [RING_ADDR_W-1:0] dest;
    logic [RING_PAY_W-1:0]  payload;
  } ring_msg_t;

  typedef struct packed {
    logic [RING_ADDR_W-1:0] dest;
    logic [RING_ADDR_W-1:0] src;
    logic [RING_PAY_W-1:0]  payload;
  } ring_flit_t;

  // Wrap an FU message into a flit stamped with the sender's address.
  function automatic ring_flit_t msg_to_flit(input ring_msg_t m, input logic [RING_ADDR_W-1:0] src);
    ring_flit_t f;
    f.dest    = m.dest;
    f.src     = src;
    f.payload = m.payload;
    return f;
  endfunction

endpackage

// File: rtl/xctcmsg_ring_rx_fifo.sv
// Synchronous RX FIFO for ejected/loopback flits. in_ready depends only on
// the pre-pop fill level, so a full FIFO never accepts in the cycle it pops.
module xctcmsg_ring_rx_fifo
  import xctcmsg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  ring_flit_t in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output ring_flit_t out_data_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);

  ring_flit_t      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            push, pop;

  assign full_o      = (cnt_q == (AW+1)'(DEPTH));
  assign in_ready_o  = !full_o;
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_q[rptr_q];
  assign push        = in_valid_i && !full_o;
  assign pop         = out_valid_o && out_ready_i;

  // Occupancy follows push/pop; simultaneous push and pop cancel.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; only valid entries are ever read out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data_i;
  end

endmodule

// File: rtl/xctcmsg_ring_stop.sv
// One stop of the unidirectional xctcmsg ring: transit forwarding, FU
// injection, ejection and local loopback into an RX FIFO.
// Optional injection fairness: define XCTCMSG_RING_FAIRNESS_EN.
module xctcmsg_ring_stop
  import xctcmsg_pkg::*;
#(
  parameter int RX_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RING_ADDR_W-1:0] local_address,
  input  logic                   fu_ring_valid,
  output logic                   ring_fu_ready,
  input  ring_msg_t              fu_ring_data,
  output logic                   ring_fu_valid,
  input  logic                   fu_ring_ready,
  output ring_flit_t             ring_fu_data,
  input  logic                   ring_in_valid,
  output logic                   ring_in_ready,
  input  ring_flit_t             ring_in_flit,
  output logic                   ring_out_valid,
  input  logic                   ring_out_ready,
  output ring_flit_t             ring_out_flit
);

  logic       out_vld_q;
  ring_flit_t out_flit_q;
  logic       out_can_load, eject, transit, fu_lb, fu_inj, force_inj;
  logic       transit_acc, inj_acc, rx_full, rx_in_ready;
  ring_flit_t fu_flit, rx_in_data;

  assign out_can_load = !out_vld_q || ring_out_ready;
  assign eject        = ring_in_valid && (ring_in_flit.dest == local_address);
  assign transit      = ring_in_valid && (ring_in_flit.dest != local_address);
  assign fu_lb        = fu_ring_valid && (fu_ring_data.dest == local_address);
  assign fu_inj       = fu_ring_valid && (fu_ring_data.dest != local_address);
  assign fu_flit      = msg_to_flit(fu_ring_data, local_address);

  // Transit normally beats injection; a forced grant flips that for one load.
  assign ring_in_ready = (ring_in_flit.dest == local_address) ? !rx_full
                                                              : (out_can_load && !force_inj);
  assign ring_fu_ready = (fu_ring_data.dest == local_address) ? (!rx_full && !eject)
                                                              : (out_can_load && (!transit || force_inj));
  assign transit_acc   = transit && ring_in_ready;
  assign inj_acc       = fu_inj && ring_fu_ready;

`ifdef XCTCMSG_RING_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  assign force_inj = (starve_q == SW'(STARVE_LIMIT));

  // Count cycles a pending inject lost only to transit; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              starve_q <= '0;
    else if (!fu_inj || inj_acc)             starve_q <= '0;
    else if (out_can_load && transit && !force_inj) starve_q <= starve_q + 1'b1;
  end
`else
  assign force_inj = 1'b0;
`endif

  // Output register: reload whenever empty or being drained downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_flit_q <= '0;
    end else if (out_can_load) begin
      out_vld_q <= transit_acc || inj_acc;
      if (transit_acc)  out_flit_q <= ring_in_flit;
      else if (inj_acc) out_flit_q <= fu_flit;
    end
  end

  assign ring_out_valid = out_vld_q;
  assign ring_out_flit  = out_flit_q;

  // Eject has priority into the RX FIFO; loopback only pushes when no eject.
  assign rx_in_data = eject ? ring_in_flit : fu_flit;

  xctcmsg_ring_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (eject || fu_lb),
    .in_ready_o  (rx_in_ready),
    .in_data_i   (rx_in_data),
    .out_valid_o (ring_fu_valid),
    .out_ready_i (fu_ring_ready),
    .out_data_o  (ring_fu_data),
    .full_o      (rx_full)
  );

  logic unused_ok;
  assign unused_ok = rx_in_ready;

endmodule

// File: tb/tb_xctcmsg_ring_stop.sv
// Directed bench for xctcmsg_ring_stop: inject, eject, FIFO full, loopback
// priority, fairness (both builds) and stall/reset behaviour.
module tb_xctcmsg_ring_stop;
  import xctcmsg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [31:0] local_address;
  logic       fu_ring_valid, ring_fu_ready, ring_fu_valid, fu_ring_ready;
  ring_msg_t  fu_ring_data;
  ring_flit_t ring_fu_data, ring_in_flit, ring_out_flit;
  logic       ring_in_valid, ring_in_ready, ring_out_valid, ring_out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xctcmsg_ring_stop #(.RX_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .local_address(local_address),
    .fu_ring_valid(fu_ring_valid), .ring_fu_ready(ring_fu_ready), .fu_ring_data(fu_ring_data),
    .ring_fu_valid(ring_fu_valid), .fu_ring_ready(fu_ring_ready), .ring_fu_data(ring_fu_data),
    .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready), .ring_in_flit(ring_in_flit),
    .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready), .ring_out_flit(ring_out_flit)
  );

  function automatic ring_flit_t mk(input logic [31:0] d, input logic [31:0] s, input logic [63:0] p);
    ring_flit_t f;
    f.dest = d; f.src = s; f.payload = p;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; local_address = 32'd5;
    fu_ring_valid = 0; fu_ring_data = '0; fu_ring_ready = 0;
    ring_in_valid = 0; ring_in_flit = '0; ring_out_ready = 1;
    nx; nx;
    chk("rst_out_valid", ring_out_valid, 1'b0);
    chk("rst_fu_valid", ring_fu_valid, 1'b0);
    rst_n = 1'b1;
    nx;

    // 1: FU inject to dest 9
    fu_ring_valid = 1; fu_ring_data.dest = 32'd9; fu_ring_data.payload = 64'hAB;
    #1 chk("inj_ready", ring_fu_ready, 1'b1);
    nx;
    fu_ring_valid = 0;
    chk("inj_out_valid", ring_out_valid, 1'b1);
    chk("inj_out_flit", ring_out_flit, mk(9, 5, 64'hAB));
    chk("inj_fu_valid", ring_fu_valid, 1'b0);
    nx;
    chk("inj_out_drop", ring_out_valid, 1'b0);

    // 2: eject
    ring_in_valid = 1; ring_in_flit = mk(5, 2, 64'h11);
    #1 chk("ej_ready", ring_in_ready, 1'b1);
    nx;
    ring_in_valid = 0;
    chk("ej_fu_valid", ring_fu_valid, 1'b1);
    chk("ej_fu_data", ring_fu_data, mk(5, 2, 64'h11));
    chk("ej_out_valid", ring_out_valid, 1'b0);
    fu_ring_ready = 1;
    nx;
    fu_ring_ready = 0;
    chk("ej_popped", ring_fu_valid, 1'b0);

    // 3: fill FIFO, fifth eject stalls until a pop
    for (int i = 0; i < 4; i++) begin
      ring_in_valid = 1; ring_in_flit = mk(5, 3, 64'h30 + 64'(i));
      #1 chk("fill_ready", ring_in_ready, 1'b1);
      nx;
    end
    ring_in_flit = mk(5, 3, 64'h34);
    #1 chk("full_block", ring_in_ready, 1'b0);
    nx;
    fu_ring_ready = 1;
    #1 chk("full_nopass", ring_in_ready, 1'b0);
    chk("full_head", ring_fu_data.payload, 64'h30);
    nx;
    fu_ring_ready = 0;
    #1 chk("fifth_ready", ring_in_ready, 1'b1);
    nx;
    ring_in_valid = 0; fu_ring_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("drain_valid", ring_fu_valid, 1'b1);
      chk("drain_order", ring_fu_data.payload, 64'h31 + 64'(k));
      nx;
    end
    fu_ring_ready = 0;
    #1 chk("drain_empty", ring_fu_valid, 1'b0);
    nx;

    // 5: eject vs loopback in the same cycle
    ring_in_valid = 1; ring_in_flit = mk(5, 7, 64'h55);
    fu_ring_valid = 1; fu_ring_data.dest = 32'd5; fu_ring_data.payload = 64'h66;
    #1 chk("pri_ej_ready", ring_in_ready, 1'b1);
    chk("pri_lb_ready", ring_fu_ready, 1'b0);
    nx;
    ring_in_valid = 0;
    #1 chk("lb_ready", ring_fu_ready, 1'b1);
    nx;
    fu_ring_valid = 0; fu_ring_ready = 1;
    #1 chk("pri_first", ring_fu_data, mk(5, 7, 64'h55));
    nx;
    #1 chk("pri_second", ring_fu_data, mk(5, 5, 64'h66));
    nx;
    fu_ring_ready = 0;
    #1 chk("pri_empty", ring_fu_valid, 1'b0);
    nx;

    // 4: transit stream with an inject pending
    fu_ring_valid = 1; fu_ring_data.dest = 32'd8; fu_ring_data.payload = 64'hEE;
    ring_in_valid = 1;
`ifdef XCTCMSG_RING_FAIRNESS_EN
    for (int i = 0; i < 8; i++) begin
      ring_in_flit = mk(9, 1, 64'(i));
      #1 chk("fair_tr_ready", ring_in_ready, 1'b1);
      chk("fair_inj_wait", ring_fu_ready, 1'b0);
      nx;
      chk("fair_tr_out", ring_out_flit, mk(9, 1, 64'(i)));
    end
    ring_in_flit = mk(9, 1, 64'd8);
    #1 chk("fair_force_tr", ring_in_ready, 1'b0);
    chk("fair_force_inj", ring_fu_ready, 1'b1);
    nx;
    chk("fair_inj_out", ring_out_flit, mk(8, 5, 64'hEE));
    fu_ring_valid = 0;
    #1 chk("fair_resume", ring_in_ready, 1'b1);
    nx;
    chk("fair_tr8_out", ring_out_flit, mk(9, 1, 64'd8));
    ring_in_valid = 0;
`else
    for (int i = 0; i < 12; i++) begin
      ring_in_flit = mk(9, 1, 64'(i));
      #1 chk("strict_tr_ready", ring_in_ready, 1'b1);
      chk("strict_inj_wait", ring_fu_ready, 1'b0);
      nx;
      chk("strict_tr_out", ring_out_flit, mk(9, 1, 64'(i)));
    end
    ring_in_valid = 0;
    #1 chk("strict_inj_ready", ring_fu_ready, 1'b1);
    nx;
    chk("strict_inj_out", ring_out_flit, mk(8, 5, 64'hEE));
    fu_ring_valid = 0;
`endif
    nx;

    // 6: downstream stall then reset mid-stall
    ring_in_valid = 1; ring_in_flit = mk(9, 1, 64'h77);
    fu_ring_valid = 1; fu_ring_data.dest = 32'd5; fu_ring_data.payload = 64'h99;
    #1 chk("st_tr_ready", ring_in_ready, 1'b1);
    chk("st_lb_ready", ring_fu_ready, 1'b1);
    nx;
    ring_out_ready = 0; fu_ring_valid = 0;
    ring_in_flit = mk(9, 1, 64'h78);
    chk("st_fu_valid", ring_fu_valid, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1 chk("st_out_valid", ring_out_valid, 1'b1);
      chk("st_out_flit", ring_out_flit, mk(9, 1, 64'h77));
      chk("st_tr_blocked", ring_in_ready, 1'b0);
      nx;
    end
    rst_n = 1'b0;
    #1 chk("rst_mid_out", ring_out_valid, 1'b0);
    chk("rst_mid_fu", ring_fu_valid, 1'b0);
    ring_in_valid = 0;
    nx;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
